// File: rtl/sdram_arbiter_pkg.sv
// Constants shared by the SDRAM controller blocks: command encodings, arbiter
// state codes and the fixed-priority grant helper.
package sdram_arbiter_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_LMR    = 4'b0000;
    localparam logic [3:0] CMD_AREF   = 4'b0001;
    localparam logic [3:0] CMD_PRECHG = 4'b0010;
    localparam logic [3:0] CMD_ACTIVE = 4'b0011;
    localparam logic [3:0] CMD_WRITE  = 4'b0100;
    localparam logic [3:0] CMD_READ   = 4'b0101;
    localparam logic [3:0] CMD_BSTOP  = 4'b0110;
    localparam logic [3:0] CMD_NOP    = 4'b0111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_ARBIT = 3'b001,
        ST_AREF  = 3'b011,
        ST_WRITE = 3'b010,
        ST_READ  = 3'b110
    } arb_state_e;

    // Refresh beats write beats read; no request means another arbitration cycle.
    function automatic arb_state_e arbit_next(input logic aref_req,
                                              input logic wr_req,
                                              input logic rd_req);
        arb_state_e nxt;
        if (aref_req) begin
            nxt = ST_AREF;
        end else if (wr_req) begin
            nxt = ST_WRITE;
        end else if (rd_req) begin
            nxt = ST_READ;
        end else begin
            nxt = ST_ARBIT;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// Client-side and device-side buses of the SDRAM arbiter (DQ stays a plain inout).
interface sdram_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 13,
    parameter int BANK_W = 2
);
    logic              init_end;
    logic [3:0]        init_cmd;
    logic [BANK_W-1:0] init_bank;
    logic [ADDR_W-1:0] init_addr;

    logic              aref_req, aref_end, aref_en;
    logic [3:0]        aref_cmd;
    logic [BANK_W-1:0] aref_bank;
    logic [ADDR_W-1:0] aref_addr;

    logic              wr_req, wr_end, wr_en, wr_sdram_en;
    logic [3:0]        wr_cmd;
    logic [BANK_W-1:0] wr_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_sdram_data;

    logic              rd_req, rd_end, rd_en;
    logic [3:0]        rd_cmd;
    logic [BANK_W-1:0] rd_bank;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_sdram_data;

    logic              grant_tmo;
    logic              sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [BANK_W-1:0] sdram_ba;
    logic [ADDR_W-1:0] sdram_addr;

    modport master (
        input  init_end, init_cmd, init_bank, init_addr,
        input  aref_req, aref_end, aref_cmd, aref_bank, aref_addr,
        input  wr_req, wr_end, wr_cmd, wr_bank, wr_addr, wr_sdram_en, wr_sdram_data,
        input  rd_req, rd_end, rd_cmd, rd_bank, rd_addr,
        output aref_en, wr_en, rd_en, rd_sdram_data, grant_tmo,
        output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        output sdram_ba, sdram_addr
    );

    modport slave (
        output init_end, init_cmd, init_bank, init_addr,
        output aref_req, aref_end, aref_cmd, aref_bank, aref_addr,
        output wr_req, wr_end, wr_cmd, wr_bank, wr_addr, wr_sdram_en, wr_sdram_data,
        output rd_req, rd_end, rd_cmd, rd_bank, rd_addr,
        input  aref_en, wr_en, rd_en, rd_sdram_data, grant_tmo,
        input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        input  sdram_ba, sdram_addr
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Single owner of the SDRAM pins: passes sdram_init through until init completes,
// then grants refresh > write > read one at a time with a grant watchdog.
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 13,
    parameter int BANK_W    = 2,
    parameter int GRANT_TMO = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    sdram_arbiter_if.master   bus,
    inout  wire  [DATA_W-1:0] sdram_dq
);

    localparam int              CNT_W    = (GRANT_TMO > 0) ? $clog2(GRANT_TMO + 1) : 1;
    localparam bit              TMO_EN   = (GRANT_TMO > 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(GRANT_TMO - 1);

    arb_state_e        state_q, state_d;
    logic              aref_en_q, aref_en_d;
    logic              wr_en_q, wr_en_d;
    logic              rd_en_q, rd_en_d;
    logic              tmo_q, tmo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              grant_end_s;
    logic              tmo_hit_s;
    logic              dq_oe_s;
    logic [3:0]        cmd_s;
    logic [BANK_W-1:0] ba_s;
    logic [ADDR_W-1:0] addr_s;

    // The grant is held for exactly GRANT_TMO cycles when no end pulse arrives.
    assign tmo_hit_s = TMO_EN && (cnt_q == TMO_LAST);

    // End pulse of whichever client currently owns the bus.
    always_comb begin
        grant_end_s = 1'b0;
        case (state_q)
            ST_AREF:  grant_end_s = bus.aref_end;
            ST_WRITE: grant_end_s = bus.wr_end;
            ST_READ:  grant_end_s = bus.rd_end;
            default:  grant_end_s = 1'b0;
        endcase
    end

    // Next state, watchdog count and the enables that mirror the next state.
    always_comb begin
        state_d = state_q;
        tmo_d   = 1'b0;
        cnt_d   = cnt_q;
        if (!bus.init_end) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_ARBIT;
                ST_ARBIT: begin
                    state_d = arbit_next(bus.aref_req, bus.wr_req, bus.rd_req);
                    cnt_d   = {CNT_W{1'b0}};
                end
                ST_AREF, ST_WRITE, ST_READ: begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
                    if (grant_end_s) begin
                        state_d = ST_ARBIT;
                    end else if (tmo_hit_s) begin
                        state_d = ST_ARBIT;
                        tmo_d   = 1'b1;
                    end else begin
                        state_d = state_q;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        aref_en_d = (state_d == ST_AREF);
        wr_en_d   = (state_d == ST_WRITE);
        rd_en_d   = (state_d == ST_READ);
    end

    // State, grant enables, timeout pulse and watchdog counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            aref_en_q <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            tmo_q     <= 1'b0;
            cnt_q     <= {CNT_W{1'b0}};
        end else begin
            state_q   <= state_d;
            aref_en_q <= aref_en_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            tmo_q     <= tmo_d;
            cnt_q     <= cnt_d;
        end
    end

    // Command/bank/address mux; clients already align their commands, so no pipeline.
    always_comb begin
        cmd_s  = CMD_NOP;
        ba_s   = {BANK_W{1'b1}};
        addr_s = {ADDR_W{1'b1}};
        case (state_q)
            ST_IDLE:  begin cmd_s = bus.init_cmd; ba_s = bus.init_bank; addr_s = bus.init_addr; end
            ST_AREF:  begin cmd_s = bus.aref_cmd; ba_s = bus.aref_bank; addr_s = bus.aref_addr; end
            ST_WRITE: begin cmd_s = bus.wr_cmd;   ba_s = bus.wr_bank;   addr_s = bus.wr_addr;   end
            ST_READ:  begin cmd_s = bus.rd_cmd;   ba_s = bus.rd_bank;   addr_s = bus.rd_addr;   end
            default:  begin cmd_s = CMD_NOP; ba_s = {BANK_W{1'b1}}; addr_s = {ADDR_W{1'b1}}; end
        endcase
    end

    assign {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n} = cmd_s;
    assign bus.sdram_ba      = ba_s;
    assign bus.sdram_addr    = addr_s;
    assign bus.sdram_cke     = 1'b1;
    assign bus.aref_en       = aref_en_q;
    assign bus.wr_en         = wr_en_q;
    assign bus.rd_en         = rd_en_q;
    assign bus.grant_tmo     = tmo_q;

    // state_q resets asynchronously, so the DQ driver releases without a clock edge.
    assign dq_oe_s           = (state_q == ST_WRITE) && bus.wr_sdram_en;
    assign sdram_dq          = dq_oe_s ? bus.wr_sdram_data : {DATA_W{1'bz}};
    assign bus.rd_sdram_data = sdram_dq;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomised bench for sdram_arbiter: a bus-ownership model predicts every cycle's
// outputs into a queue and a negedge monitor compares them with the DUT.
module tb_sdram_arbiter;
    import sdram_arbiter_pkg::*;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 13;
    localparam int BANK_W = 2;
    localparam int TMO    = 16;
    localparam int PRE    = 0;  // init still running: pins follow sdram_init
    localparam int FREE   = 1;  // nobody owns the bus
    localparam int OWNED  = 2;  // m_owner owns the bus (0 refresh, 1 write, 2 read)

    typedef struct packed {
        logic              aref_en, wr_en, rd_en, tmo, cke;
        logic [3:0]        cmd;
        logic [BANK_W-1:0] ba;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] dq, rdd;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;
    logic tb_drv;
    logic [DATA_W-1:0] tb_dq;
    wire  [DATA_W-1:0] sdram_dq;

    assign sdram_dq = tb_drv ? tb_dq : {DATA_W{1'bz}};
    always #5 clk = ~clk;

    sdram_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BANK_W(BANK_W)) bus();

    sdram_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BANK_W(BANK_W), .GRANT_TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .sdram_dq(sdram_dq)
    );

    obs_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   m_phase, m_owner, m_held;
    bit   m_tmo;
    bit   req [3];
    int   blen [3];      // cycles a client keeps its grant before end; 0 = never ends
    bit   rnd_mode;
    bit   dir_beats;

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.aref_en = bus.aref_en;
        o.wr_en   = bus.wr_en;
        o.rd_en   = bus.rd_en;
        o.tmo     = bus.grant_tmo;
        o.cke     = bus.sdram_cke;
        o.cmd     = {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n};
        o.ba      = bus.sdram_ba;
        o.addr    = bus.sdram_addr;
        o.dq      = sdram_dq;
        o.rdd     = bus.rd_sdram_data;
        return o;
    endfunction

    task automatic model_reset();
        m_phase = PRE;
        m_owner = 0;
        m_held  = 0;
        m_tmo   = 1'b0;
    endtask

    // Ownership rules applied at each rising edge to the inputs seen at that edge.
    task automatic model_step();
        logic [2:0] reqv;
        logic [2:0] endv;
        int pick;
        reqv  = {bus.rd_req, bus.wr_req, bus.aref_req};
        endv  = {bus.rd_end, bus.wr_end, bus.aref_end};
        m_tmo = 1'b0;
        if (!bus.init_end) begin
            m_phase = PRE;
        end else if (m_phase == PRE) begin
            m_phase = FREE;
        end else if (m_phase == FREE) begin
            pick = -1;
            for (int c = 2; c >= 0; c--) if (reqv[c]) pick = c;  // lower index wins
            if (pick >= 0) begin
                m_phase = OWNED;
                m_owner = pick;
                m_held  = 0;
            end
        end else begin
            m_held++;
            if (endv[m_owner]) begin
                m_phase = FREE;
            end else if (m_held == TMO) begin
                m_phase = FREE;
                m_tmo   = 1'b1;
            end
        end
    endtask

    // Client behaviour for this cycle plus the prediction pushed to the scoreboard.
    task automatic set_inputs();
        logic [2:0] endv;
        logic       exp_drive;
        obs_t       e;
        endv = 3'b000;
        if (m_phase == OWNED) begin
            req[m_owner] = 1'b0;
            if (blen[m_owner] != 0 && m_held == blen[m_owner] - 1) endv[m_owner] = 1'b1;
        end
        if (rnd_mode) begin
            for (int c = 0; c < 3; c++) begin
                if (!(m_phase == OWNED && m_owner == c)) begin
                    if (!req[c] && $urandom_range(0, 5) == 0) begin
                        req[c]  = 1'b1;
                        blen[c] = $urandom_range(0, TMO + 3);
                    end
                    if ($urandom_range(0, 15) == 0) endv[c] = 1'b1;
                end
            end
        end
        bus.aref_req = req[0];  bus.wr_req = req[1];  bus.rd_req = req[2];
        bus.aref_end = endv[0]; bus.wr_end = endv[1]; bus.rd_end = endv[2];
        bus.init_cmd = 4'($urandom); bus.init_bank = BANK_W'($urandom); bus.init_addr = ADDR_W'($urandom);
        bus.aref_cmd = 4'($urandom); bus.aref_bank = BANK_W'($urandom); bus.aref_addr = ADDR_W'($urandom);
        bus.wr_cmd   = 4'($urandom); bus.wr_bank   = BANK_W'($urandom); bus.wr_addr   = ADDR_W'($urandom);
        bus.rd_cmd   = 4'($urandom); bus.rd_bank   = BANK_W'($urandom); bus.rd_addr   = ADDR_W'($urandom);
        if (dir_beats) begin
            bus.wr_sdram_en   = (m_phase == OWNED && m_owner == 1 && m_held < 10);
            bus.wr_sdram_data = DATA_W'(m_held + 1);
        end else begin
            bus.wr_sdram_en   = 1'($urandom_range(0, 1));
            bus.wr_sdram_data = DATA_W'($urandom_range(1, 65535));
        end
        exp_drive = (m_phase == OWNED && m_owner == 1 && bus.wr_sdram_en);
        tb_drv    = !exp_drive;
        tb_dq     = DATA_W'($urandom);
        e.aref_en = (m_phase == OWNED && m_owner == 0);
        e.wr_en   = (m_phase == OWNED && m_owner == 1);
        e.rd_en   = (m_phase == OWNED && m_owner == 2);
        e.tmo     = m_tmo;
        e.cke     = 1'b1;
        if (m_phase == PRE) begin
            e.cmd = bus.init_cmd; e.ba = bus.init_bank; e.addr = bus.init_addr;
        end else if (m_phase == FREE) begin
            e.cmd = CMD_NOP; e.ba = {BANK_W{1'b1}}; e.addr = {ADDR_W{1'b1}};
        end else if (m_owner == 0) begin
            e.cmd = bus.aref_cmd; e.ba = bus.aref_bank; e.addr = bus.aref_addr;
        end else if (m_owner == 1) begin
            e.cmd = bus.wr_cmd; e.ba = bus.wr_bank; e.addr = bus.wr_addr;
        end else begin
            e.cmd = bus.rd_cmd; e.ba = bus.rd_bank; e.addr = bus.rd_addr;
        end
        e.dq  = exp_drive ? bus.wr_sdram_data : tb_dq;
        e.rdd = e.dq;
        exp_q.push_back(e);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            set_inputs();
            @(posedge clk);
            model_step();
            #1;
        end
    endtask

    task automatic clear_reqs();
        for (int c = 0; c < 3; c++) begin
            req[c]  = 1'b0;
            blen[c] = 0;
        end
    endtask

    always @(negedge clk) begin : monitor
        obs_t e;
        obs_t a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = sample();
            n_vec++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL outputs @%0t: got %h required %h", $time, a, e);
            end
        end
    end

    initial begin
        rst_n = 1'b0; tb_drv = 1'b1; tb_dq = 16'hA5A5;
        rnd_mode = 1'b0; dir_beats = 1'b0;
        clear_reqs();
        model_reset();
        bus.init_end = 1'b0; bus.init_cmd = 4'h0; bus.init_bank = '0; bus.init_addr = '0;
        bus.aref_req = 1'b0; bus.aref_end = 1'b0; bus.aref_cmd = 4'h0; bus.aref_bank = '0; bus.aref_addr = '0;
        bus.wr_req = 1'b0; bus.wr_end = 1'b0; bus.wr_cmd = 4'h0; bus.wr_bank = '0; bus.wr_addr = '0;
        bus.wr_sdram_en = 1'b1; bus.wr_sdram_data = 16'h1234;
        bus.rd_req = 1'b0; bus.rd_end = 1'b0; bus.rd_cmd = 4'h0; bus.rd_bank = '0; bus.rd_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_aref_en", 64'(bus.aref_en), 64'd0);
        check("rst_wr_en", 64'(bus.wr_en), 64'd0);
        check("rst_rd_en", 64'(bus.rd_en), 64'd0);
        check("rst_grant_tmo", 64'(bus.grant_tmo), 64'd0);
        check("rst_cke", 64'(bus.sdram_cke), 64'd1);
        check("rst_dq_released", 64'(sdram_dq), 64'hA5A5);
        rst_n = 1'b1;

        // init running: pins follow sdram_init, client requests ignored
        rnd_mode = 1'b1;
        run(200);
        rnd_mode = 1'b0;
        clear_reqs();

        // first write after init: 10 beats of data 1..10 then wr_end
        dir_beats = 1'b1;
        bus.init_end = 1'b1;
        req[1] = 1'b1; blen[1] = 11;
        run(20);

        // all three request together
        req[0] = 1'b1; blen[0] = 5;
        req[1] = 1'b1; blen[1] = 11;
        req[2] = 1'b1; blen[2] = 6;
        run(40);

        // refresh arrives mid-write alongside a read
        req[1] = 1'b1; blen[1] = 11;
        run(5);
        req[0] = 1'b1; blen[0] = 4;
        req[2] = 1'b1; blen[2] = 3;
        run(30);

        // read that never ends: watchdog revokes it
        req[2] = 1'b1; blen[2] = 0;
        run(TMO + 6);

        // random traffic with spurious ends and occasional init_end drops
        dir_beats = 1'b0;
        rnd_mode  = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            bus.init_end = ($urandom_range(0, 299) != 0);
            run(1);
        end

        // asynchronous reset in the middle of a write that is driving DQ
        rnd_mode = 1'b0;
        clear_reqs();
        bus.init_end = 1'b1;
        run(TMO + 4);
        req[1] = 1'b1; blen[1] = 0;
        run(3);
        bus.wr_sdram_en = 1'b1; bus.wr_sdram_data = 16'h5A3C; tb_drv = 1'b0;
        #1;
        check("wr_dq_driven", 64'(sdram_dq), 64'h5A3C);
        check("wr_en_before_rst", 64'(bus.wr_en), 64'd1);
        rst_n = 1'b0; tb_dq = 16'hA5C3; tb_drv = 1'b1;
        #1;
        check("async_rst_wr_en", 64'(bus.wr_en), 64'd0);
        check("async_rst_dq_released", 64'(sdram_dq), 64'hA5C3);
        check("async_rst_rd_data", 64'(bus.rd_sdram_data), 64'hA5C3);
        check("async_rst_cmd_init", 64'({bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n}),
              64'(bus.init_cmd));
        repeat (2) @(posedge clk);
        #1;
        bus.init_end = 1'b0;
        clear_reqs();
        model_reset();
        rst_n = 1'b1;
        run(10);
        check("state_idle_after_rst", 64'(dut.state_q), 64'(ST_IDLE));
        bus.init_end = 1'b1;
        run(6);
        check("state_arbit_after_init", 64'(dut.state_q), 64'(ST_ARBIT));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
